// File: rtl/rx_led_pkg.sv
// Shared constants for the UART-to-LED controller: display modes, playback FSM
// states and the default bit divisor.
package rx_led_pkg;

   // Clocks per bit for 9600 baud on a 12 MHz board clock
   localparam int B9600 = 1250;

   typedef enum logic [1:0] {
      MODE_LATCH    = 2'd0,
      MODE_PLAYBACK = 2'd1,
      MODE_COUNT    = 2'd2,
      MODE_TOGGLE   = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; an extra pointer bit
// distinguishes full from empty.
module rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_push, do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, a simultaneous pop frees the slot being written
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: samples each bit mid-cell and emits a one-cycle rcv
// pulse with the received byte on data.
module uart_rx import rx_led_pkg::*; #(
   parameter int BAUDRATE = B9600
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic       rcv,
   output logic [7:0] data
);
   localparam int DW = $clog2(BAUDRATE);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_st_t;

   rx_st_t        st, st_n;
   logic          rx_m, rx_s;
   logic [DW-1:0] div;
   logic [2:0]    bitn;
   logic [7:0]    sh;
   logic          tick;

   assign tick = (div == '0);

   always_ff @(posedge clk) begin
      if (!rstn) st <= RX_IDLE;
      else       st <= st_n;
   end

   always_comb begin
      st_n = st;
      case (st)
         RX_IDLE:  if (!rx_s) st_n = RX_START;
         RX_START: if (tick) st_n = rx_s ? RX_IDLE : RX_BITS;
         RX_BITS:  if (tick && bitn == 3'd7) st_n = RX_STOP;
         RX_STOP:  if (tick) st_n = RX_IDLE;
         default:  st_n = RX_IDLE;
      endcase
   end

   // A frame with a broken stop bit is silently discarded
   assign rcv  = (st == RX_STOP) && tick && rx_s;
   assign data = sh;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         div  <= '0;
         bitn <= '0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         if (st == RX_IDLE) begin
            div  <= DW'(BAUDRATE / 2);
            bitn <= '0;
         end else if (tick) begin
            div <= DW'(BAUDRATE - 1);
            if (st == RX_BITS) bitn <= bitn + 3'd1;
         end else begin
            div <= div - DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (st == RX_BITS && tick) sh <= {rx_s, sh[7:1]};
   end

endmodule

// File: rtl/rx_led_ctrl.sv
// UART-to-LED display controller: latch, timed FIFO playback, byte count and
// bit-toggle display modes selected at run time.
module rx_led_ctrl import rx_led_pkg::*; #(
   parameter int BAUDRATE    = B9600,
   parameter int NLEDS       = 8,
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 12_000_000
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             rx,
   input  logic [1:0]       mode,
   output logic [NLEDS-1:0] leds,
   output logic             overflow,
   output logic             busy
);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [NLEDS-1:0] ONE = NLEDS'(1);

   logic             rcv;
   logic [7:0]       data;
   logic [7:0]       head;
   logic             full, empty, push, pop, chg;
   mode_t            mode_q, mode_act;
   state_t           state, state_n;
   logic [HW-1:0]    hold;
   logic [NLEDS-1:0] cnt;

   uart_rx #(.BAUDRATE(BAUDRATE)) u_rx (
      .clk  (clk),
      .rstn (rstn),
      .rx   (rx),
      .rcv  (rcv),
      .data (data)
   );

   // mode_q registers the pin; the flush fires one edge later when mode_act catches up
   assign chg  = (mode_q != mode_act);
   assign push = rcv && !chg && (mode_q == MODE_PLAYBACK);

   rx_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .flush (chg),
      .din   (data),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (chg || mode_q != MODE_PLAYBACK) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (!empty) state_n = ST_SHOW;
            ST_SHOW: if (hold == '0 && empty) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      pop = 1'b0;
      if (!chg && mode_q == MODE_PLAYBACK && !empty)
         pop = (state == ST_IDLE) || (hold == '0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mode_q   <= MODE_LATCH;
         mode_act <= MODE_LATCH;
         leds     <= '0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         cnt      <= '0;
         hold     <= '0;
      end else begin
         mode_q   <= mode_t'(mode);
         mode_act <= mode_q;
         busy     <= (mode_q == MODE_PLAYBACK) && (state == ST_SHOW || !empty);
         if (push && full && !pop) overflow <= 1'b1;
         if (chg) begin
            leds <= '0;
            cnt  <= '0;
         end else begin
            case (mode_q)
               MODE_LATCH: if (rcv) leds <= data[NLEDS-1:0];
               MODE_PLAYBACK: begin
                  if (pop) begin
                     leds <= head[NLEDS-1:0];
                     hold <= HW'(HOLD_CYCLES - 1);
                  end else if (state == ST_SHOW && hold != '0) begin
                     hold <= hold - HW'(1);
                  end
               end
               MODE_COUNT: if (rcv) begin
                  cnt  <= cnt + ONE;
                  leds <= cnt + ONE;
               end
               MODE_TOGGLE: if (rcv && int'(data) < NLEDS)
                  leds <= leds ^ (ONE << data[2:0]);
               default: ;
            endcase
         end
      end
   end

endmodule
